// File: rtl/morse_encoder.sv
// Morse letter serialiser (S..Z) driving a single LED, one unit = TICK_CYCLES clocks.
// Optional trailing inter-letter gap of three units is enabled by defining MORSE_TRAILING_GAP_EN.
module morse_encoder #(
    parameter int unsigned TICK_CYCLES = 25000000,
    parameter int unsigned CNT_W       = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] letter_sel,
    output logic       led,
    output logic       busy,
    output logic       done
);

`ifdef MORSE_TRAILING_GAP_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2} state_t;
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(32'd3 * TICK_CYCLES - 32'd1);
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

    localparam logic [CNT_W-1:0] UNIT_LOAD = CNT_W'(TICK_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t      state_r, state_s;
    logic [12:0] shreg_r, shreg_s;
    logic [3:0]  remain_r, remain_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;

    // Left-aligned on/off unit pattern for each letter; the MSB is the first unit sent.
    function automatic logic [12:0] pattern_of(input logic [2:0] sel);
        logic [12:0] p;
        case (sel)
            3'd0:    p = 13'b1010100000000;
            3'd1:    p = 13'b1110000000000;
            3'd2:    p = 13'b1010111000000;
            3'd3:    p = 13'b1010101110000;
            3'd4:    p = 13'b1011101110000;
            3'd5:    p = 13'b1110101011100;
            3'd6:    p = 13'b1110101110111;
            3'd7:    p = 13'b1110111010100;
            default: p = 13'b0000000000000;
        endcase
        return p;
    endfunction

    // Number of units occupied by each letter's pattern.
    function automatic logic [3:0] length_of(input logic [2:0] sel);
        logic [3:0] n;
        case (sel)
            3'd0:    n = 4'd5;
            3'd1:    n = 4'd3;
            3'd2:    n = 4'd7;
            3'd3:    n = 4'd9;
            3'd4:    n = 4'd9;
            3'd5:    n = 4'd11;
            3'd6:    n = 4'd13;
            3'd7:    n = 4'd11;
            default: n = 4'd0;
        endcase
        return n;
    endfunction

    // Next-state, datapath and output decode.
    always_comb begin
        state_s  = state_r;
        shreg_s  = shreg_r;
        remain_s = remain_r;
        cnt_s    = cnt_r;
        busy_s   = busy_r;
        done_s   = 1'b0;
        case (state_r)
            IDLE: begin
                busy_s = 1'b0;
                if (start) begin
                    shreg_s  = pattern_of(letter_sel);
                    remain_s = length_of(letter_sel);
                    cnt_s    = UNIT_LOAD;
                    busy_s   = 1'b1;
                    state_s  = SHIFT;
                end else begin
                    shreg_s = 13'd0;
                end
            end
            SHIFT: begin
                if (cnt_r != CNT_ZERO) begin
                    cnt_s = cnt_r - CNT_ONE;
                end else if (remain_r > 4'd1) begin
                    shreg_s  = {shreg_r[11:0], 1'b0};
                    remain_s = remain_r - 4'd1;
                    cnt_s    = UNIT_LOAD;
                end else begin
                    // Clearing the shifter forces the LED dark once the pattern is spent.
                    shreg_s  = 13'd0;
                    remain_s = 4'd0;
`ifdef MORSE_TRAILING_GAP_EN
                    cnt_s    = GAP_LOAD;
                    state_s  = GAP;
`else
                    busy_s   = 1'b0;
                    done_s   = 1'b1;
                    state_s  = IDLE;
`endif
                end
            end
`ifdef MORSE_TRAILING_GAP_EN
            GAP: begin
                if (cnt_r != CNT_ZERO) begin
                    cnt_s = cnt_r - CNT_ONE;
                end else begin
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    state_s = IDLE;
                end
            end
`endif
            default: begin
                state_s  = IDLE;
                shreg_s  = 13'd0;
                remain_s = 4'd0;
                cnt_s    = CNT_ZERO;
                busy_s   = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r  <= IDLE;
            shreg_r  <= 13'd0;
            remain_r <= 4'd0;
            cnt_r    <= CNT_ZERO;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            shreg_r  <= shreg_s;
            remain_r <= remain_s;
            cnt_r    <= cnt_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
        end
    end

    assign led  = shreg_r[12];
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_morse_encoder.sv
// Directed, table-driven bench for morse_encoder at TICK_CYCLES of 4, 2 and 1.
// Expectations follow MORSE_TRAILING_GAP_EN when the bench is built with it defined.
module tb_morse_encoder;

`ifdef MORSE_TRAILING_GAP_EN
    localparam int GAP_UNITS = 3;
`else
    localparam int GAP_UNITS = 0;
`endif

    typedef struct {
        logic       start;
        logic [2:0] sel;
        logic [2:0] exp;   // {led, busy, done} one cycle after the inputs are applied
    } vec_t;

    logic       clock;
    logic       reset;
    logic [2:0] start_v;
    logic [2:0] sel_v [3];
    logic [2:0] led_v, busy_v, done_v;

    int checks;
    int failures;
    vec_t vq[$];

    morse_encoder #(.TICK_CYCLES(4), .CNT_W(32)) u_t4 (
        .clock(clock), .reset(reset), .start(start_v[0]), .letter_sel(sel_v[0]),
        .led(led_v[0]), .busy(busy_v[0]), .done(done_v[0]));
    morse_encoder #(.TICK_CYCLES(2), .CNT_W(32)) u_t2 (
        .clock(clock), .reset(reset), .start(start_v[1]), .letter_sel(sel_v[1]),
        .led(led_v[1]), .busy(busy_v[1]), .done(done_v[1]));
    morse_encoder #(.TICK_CYCLES(1), .CNT_W(8)) u_t1 (
        .clock(clock), .reset(reset), .start(start_v[2]), .letter_sel(sel_v[2]),
        .led(led_v[2]), .busy(busy_v[2]), .done(done_v[2]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [2:0] obs(input int d);
        return {led_v[d], busy_v[d], done_v[d]};
    endfunction

    task automatic check(input string nm, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: led/busy/done got %b expected %b", nm, act, exp);
        end
    endtask

    // Expand a hand-written pattern into per-cycle vectors (unit j lasts tick cycles).
    task automatic build(input int tick, input logic [2:0] sel, input logic [12:0] pat,
                         input int len, input bit tail);
        vec_t v;
        int busy_n;
        busy_n = (len + GAP_UNITS) * tick;
        for (int j = 0; j <= busy_n; j++) begin
            v.start = (j == 0);
            v.sel   = sel;
            if (j < busy_n)
                v.exp = {((j / tick) < len) ? pat[12 - (j / tick)] : 1'b0, 1'b1, 1'b0};
            else
                v.exp = 3'b001;
            vq.push_back(v);
        end
        if (tail) begin
            v.start = 1'b0;
            v.sel   = sel;
            v.exp   = 3'b000;
            vq.push_back(v);
        end
    endtask

    task automatic run_vecs(input int d, input string nm);
        for (int i = 0; i < vq.size(); i++) begin
            start_v[d] = vq[i].start;
            sel_v[d]   = vq[i].sel;
            @(posedge clock); #1;
            check($sformatf("%s[%0d]", nm, i), obs(d), vq[i].exp);
        end
        start_v[d] = 1'b0;
        vq.delete();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        start_v  = 3'b111;
        for (int d = 0; d < 3; d++) sel_v[d] = 3'd0;

        // Reset held with start asserted: everything stays dark.
        for (int c = 0; c < 2; c++) begin
            @(posedge clock); #1;
            for (int d = 0; d < 3; d++) check($sformatf("reset_hold%0d_dut%0d", c, d), obs(d), 3'b000);
        end
        reset   = 1'b0;
        start_v = 3'b000;
        for (int c = 0; c < 2; c++) begin
            @(posedge clock); #1;
            for (int d = 0; d < 3; d++) check($sformatf("reset_idle%0d_dut%0d", c, d), obs(d), 3'b000);
        end

        // Letter S at four cycles per unit.
        build(4, 3'd0, 13'b1010100000000, 5, 1'b1);
        run_vecs(0, "S_t4");

        // Letter Y at two cycles per unit.
        build(2, 3'd6, 13'b1110101110111, 13, 1'b1);
        run_vecs(1, "Y_t2");

        // T with a stray start and sel change mid-flight, then Z started on the done cycle.
        build(4, 3'd1, 13'b1110000000000, 3, 1'b0);
        for (int i = 1; i < vq.size(); i++) vq[i].sel = 3'd7;
        vq[2].start = 1'b1;
        build(4, 3'd7, 13'b1110111010100, 11, 1'b1);
        run_vecs(0, "T_then_Z");

        // Reset in the middle of X aborts with no done pulse.
        start_v[1] = 1'b1;
        sel_v[1]   = 3'd5;
        @(posedge clock); #1;
        start_v[1] = 1'b0;
        repeat (5) begin
            @(posedge clock); #1;
        end
        check("X_before_reset", obs(1), 3'b110);
        reset = 1'b1;
        @(posedge clock); #1;
        check("X_reset_abort", obs(1), 3'b000);
        reset = 1'b0;
        @(posedge clock); #1;
        check("X_no_done", obs(1), 3'b000);
        build(2, 3'd5, 13'b1110101011100, 11, 1'b1);
        run_vecs(1, "X_restart");

        // Single-cycle units.
        build(1, 3'd1, 13'b1110000000000, 3, 1'b1);
        run_vecs(2, "T_t1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
